// File: rtl/door_opener_timed_pkg.sv
// Shared types for the timed door opener.
// State encodings and the timer-width helper.
package door_opener_timed_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_CLOSED  = 3'd1,
    ST_OPENING = 3'd2,
    ST_OPEN    = 3'd3,
    ST_CLOSING = 3'd4,
    ST_STOPPED = 3'd5,
    ST_FAULT   = 3'd6,
    ST_BAD     = 3'd7
  } state_t;

  function automatic int cw_of(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/door_opener_timed_if.sv
// Door opener sensor/motor bundle.
// master drives the sensors, slave drives the motor.
interface door_opener_timed_if;
  logic       b;
  logic       c;
  logic       o;
  logic       s;
  logic       u;
  logic       d;
  logic [2:0] state;
  logic       fault;

  modport master (
    output b, c, o, s,
    input  u, d, state, fault
  );

  modport slave (
    input  b, c, o, s,
    output u, d, state, fault
  );
endinterface

// File: rtl/door_opener_timed_timer.sv
// Saturating up-counter used for travel and auto-close timing.
// clr wins over en; counting stops at all-ones.
module door_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/door_opener_timed.sv
// Timed door opener FSM with travel watchdog and auto-close.
// Outputs are decoded from the registered state only.
module door_opener_timed
  import door_opener_timed_pkg::*;
#(
  parameter int AUTO_CLOSE = 100,
  parameter int TRAVEL_MAX = 500
) (
  input logic               clk,
  input logic               r_n,
  door_opener_timed_if.slave io
);

  localparam int CW = cw_of(AUTO_CLOSE, TRAVEL_MAX);
  localparam int AC_M1 = (AUTO_CLOSE > 0) ? AUTO_CLOSE - 1 : 0;
  localparam int TM_M1 = (TRAVEL_MAX > 0) ? TRAVEL_MAX - 1 : 0;
  localparam logic [CW-1:0] AC_END = CW'(AC_M1);
  localparam logic [CW-1:0] TM_END = CW'(TM_M1);
  localparam bit AC_ON = (AUTO_CLOSE != 0);

  state_t        st;
  state_t        nx;
  logic          b_q;
  logic          b_edge;
  logic          last_dir;
  logic [CW-1:0] tmr;
  logic          t_en;
  logic          t_clr;
  logic          t_end;
  logic          a_end;

  assign b_edge = io.b & ~b_q;
  assign t_end  = (tmr == TM_END);
  assign a_end  = AC_ON && (tmr == AC_END);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      st       <= ST_INIT;
      b_q      <= 1'b0;
      last_dir <= 1'b1;
    end else begin
      st  <= nx;
      b_q <= io.b;
      if (nx != st) begin
        if (nx == ST_OPENING) last_dir <= 1'b1;
        if (nx == ST_CLOSING) last_dir <= 1'b0;
      end
    end
  end

  always_comb begin
    nx = st;
    if (st != ST_FAULT && io.c && io.o) begin
      nx = ST_FAULT;
    end else begin
      case (st)
        ST_INIT: begin
          if (io.o)      nx = ST_OPEN;
          else if (io.c) nx = ST_CLOSED;
          else           nx = ST_OPENING;
        end
        ST_CLOSED: begin
          if (b_edge) nx = ST_OPENING;
        end
        ST_OPENING: begin
          if (io.o)        nx = ST_OPEN;
          else if (t_end)  nx = ST_FAULT;
          else if (b_edge) nx = ST_STOPPED;
        end
        ST_OPEN: begin
          if (!io.s && (b_edge || a_end))
            nx = ST_CLOSING;
        end
        ST_CLOSING: begin
          if (io.s)        nx = ST_OPENING;
          else if (io.c)   nx = ST_CLOSED;
          else if (t_end)  nx = ST_FAULT;
          else if (b_edge) nx = ST_STOPPED;
        end
        ST_STOPPED: begin
          if (b_edge)
            nx = (last_dir && !io.s) ? ST_CLOSING
                                     : ST_OPENING;
        end
        ST_FAULT: nx = ST_FAULT;
        default:  nx = ST_FAULT;
      endcase
    end
  end

  // obstacle in OPEN restarts the auto-close count
  always_comb begin
    t_en  = (st == ST_OPENING) || (st == ST_CLOSING)
         || (st == ST_OPEN);
    t_clr = (nx != st) || !t_en
         || ((st == ST_OPEN) && io.s);
  end

  door_timer #(.CW(CW)) u_tmr (
    .clk (clk),
    .r_n (r_n),
    .clr (t_clr),
    .en  (t_en),
    .q   (tmr)
  );

  always_comb begin
    io.u     = 1'b0;
    io.d     = 1'b0;
    io.fault = 1'b0;
    io.state = st;
    unique case (1'b1)
      (st == ST_OPENING): io.u     = 1'b1;
      (st == ST_CLOSING): io.d     = 1'b1;
      (st == ST_FAULT):   io.fault = 1'b1;
      default: ;
    endcase
  end

endmodule
